// File: rtl/pb_debouncer.sv
// -----------------------------------------------------------------------------
// pb_debouncer
//
// Conditions a raw, bouncing pushbutton into a clean level for the one-pulse
// stage. The button is first brought into the clk domain by a two-flop
// synchroniser. Every level change is then qualified by a four-state FSM with a
// stability counter. pb_db only changes after the synchronised input has held
// the new level for STABLE_CYCLES consecutive qualifying cycles.
//
// Parameters:
//   STABLE_CYCLES - qualifying cycles needed to accept a change (>= 1)
//   CNT_W         - qualification counter width, 2**CNT_W > STABLE_CYCLES
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   pb_raw     in   raw pushbutton, asynchronous to clk, may bounce
//   pb_db      out  debounced level (HIGH or HIGH_QUAL)
//   pb_busy    out  level change under qualification (LOW_QUAL or HIGH_QUAL)
//   dbg_state  out  current FSM state encoding, for debug and checkers
//   dbg_cnt    out  current qualification count, for debug and checkers
// -----------------------------------------------------------------------------
module pb_debouncer #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pb_raw,
    output logic             pb_db,
    output logic             pb_busy,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_cnt
);

    // The counter must be able to hold STABLE_CYCLES-1 without wrapping.
    generate
        if (STABLE_CYCLES < 1 || (CNT_W < 31 && (2 ** CNT_W) <= STABLE_CYCLES)) begin : g_bad_params
            $error("pb_debouncer: need STABLE_CYCLES >= 1 and 2**CNT_W > STABLE_CYCLES");
        end
    endgenerate

    localparam logic [1:0] ST_LOW       = 2'b00;
    localparam logic [1:0] ST_LOW_QUAL  = 2'b01;
    localparam logic [1:0] ST_HIGH      = 2'b10;
    localparam logic [1:0] ST_HIGH_QUAL = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic             pb_sync;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Two-flop synchroniser; only sync2 is consumed downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pb_raw;
            sync2 <= sync1;
        end
    end

    assign pb_sync = sync2;

    // Next-state logic. The counter restarts from zero on every state change,
    // so an aborted attempt never leaves a partial count behind.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            ST_LOW: begin
                if (pb_sync) begin
                    state_nxt = ST_LOW_QUAL;
                end
            end
            ST_LOW_QUAL: begin
                if (!pb_sync) begin
                    state_nxt = ST_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_HIGH;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!pb_sync) begin
                    state_nxt = ST_HIGH_QUAL;
                end
            end
            ST_HIGH_QUAL: begin
                if (pb_sync) begin
                    state_nxt = ST_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_LOW;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_LOW;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs decode registered state only, so they cannot glitch.
    assign pb_db     = (state == ST_HIGH) || (state == ST_HIGH_QUAL);
    assign pb_busy   = (state == ST_LOW_QUAL) || (state == ST_HIGH_QUAL);
    assign dbg_state = state;
    assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_pb_debouncer.sv
// -----------------------------------------------------------------------------
// tb_pb_debouncer
//
// Self-checking bench for pb_debouncer with STABLE_CYCLES = 4. A cycle model
// predicts pb_db / pb_busy for every driven pb_raw sample; predictions are
// queued when the stimulus is driven and compared after the clock edge.
// Latencies called out for the button are also checked against fixed numbers.
// A small one-pulse stage downstream counts clk_en pulses end to end.
// -----------------------------------------------------------------------------
module tb_pb_debouncer;

    localparam int S     = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             pb_raw;
    logic             pb_db;
    logic             pb_busy;
    logic [1:0]       dbg_state;
    logic [CNT_W-1:0] dbg_cnt;

    pb_debouncer #(
        .STABLE_CYCLES (S),
        .CNT_W         (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pb_raw    (pb_raw),
        .pb_db     (pb_db),
        .pb_busy   (pb_busy),
        .dbg_state (dbg_state),
        .dbg_cnt   (dbg_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- downstream one-pulse stage ----------------
    logic db_d;
    logic clk_en;
    always @(posedge clk or posedge rst) begin
        if (rst) db_d <= 1'b0;
        else     db_d <= pb_db;
    end
    assign clk_en = pb_db & ~db_d;

    // ---------------- scoreboard / bookkeeping ----------------
    logic [1:0] exp_q[$];
    int n_checks;
    int n_fail;
    int pulse_cnt;
    int pulse_run;
    int pulse_max;
    logic seen_db;
    logic seen_busy;

    // Reference model: two-stage input delay, then a run length of samples
    // that disagree with the accepted level. The (S+1)th disagreeing sample
    // in a row flips the level.
    logic m_s1;
    logic m_s2;
    logic m_db;
    int   m_run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1  = 1'b0;
        m_s2  = 1'b0;
        m_db  = 1'b0;
        m_run = 0;
    endtask

    task automatic model_edge(input logic raw);
        logic sample;
        sample = m_s2;
        if (sample != m_db) begin
            m_run++;
            if (m_run == S + 1) begin
                m_db  = ~m_db;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    // Drive one pb_raw value for the coming rising edge and check the result.
    task automatic step(input logic raw);
        logic [1:0] e;
        @(negedge clk);
        pb_raw = raw;
        model_edge(raw);
        exp_q.push_back({m_db, (m_run != 0)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pb_db", {31'd0, pb_db}, {31'd0, e[1]});
        check("pb_busy", {31'd0, pb_busy}, {31'd0, e[0]});
        if (pb_db)   seen_db   = 1'b1;
        if (pb_busy) seen_busy = 1'b1;
        if (clk_en) begin
            pulse_cnt++;
            pulse_run++;
            if (pulse_run > pulse_max) pulse_max = pulse_run;
        end else begin
            pulse_run = 0;
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_db"}, {31'd0, pb_db}, 32'd0);
        check({tag, "_busy"}, {31'd0, pb_busy}, 32'd0);
        check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
        check({tag, "_cnt"}, {24'd0, dbg_cnt}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic clear_flags();
        seen_db   = 1'b0;
        seen_busy = 1'b0;
        pulse_cnt = 0;
        pulse_run = 0;
        pulse_max = 0;
    endtask

    // ---------------- stimulus ----------------
    int rise_at;
    int fall_at;
    logic [5:0] bounce_pat;
    logic [5:0] release_pat;
    logic lvl;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        bounce_pat  = 6'b101101;   // driven MSB first: 1,0,1,1,0,1
        release_pat = 6'b010010;   // driven MSB first: 0,1,0,0,1,0
        clear_flags();
        model_reset();
        pb_raw = 1'b0;
        rst    = 1'b1;

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        check("por_db", {31'd0, pb_db}, 32'd0);
        check("por_busy", {31'd0, pb_busy}, 32'd0);
        check("por_state", {30'd0, dbg_state}, 32'd0);
        check("por_cnt", {24'd0, dbg_cnt}, 32'd0);
        #1;
        rst = 1'b0;
        repeat (4) step(1'b0);

        // Clean press held 20 cycles, then release.
        clear_flags();
        rise_at = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            if (i == 4) check("press_cnt_mid", {24'd0, dbg_cnt}, 32'd2);
            if (pb_db && rise_at < 0) rise_at = i;
        end
        check("press_rise_lat", rise_at, 32'd6);
        fall_at = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0);
            if (!pb_db && fall_at < 0) fall_at = i;
        end
        check("release_fall_lat", fall_at, 32'd6);
        check("press_pulses", pulse_cnt, 32'd1);

        // Bounce on press.
        repeat (4) step(1'b0);
        clear_flags();
        rise_at = -1;
        for (int i = 0; i < 18; i++) begin
            step(i < 6 ? bounce_pat[5 - i] : 1'b1);
            if (pb_db && rise_at < 0) rise_at = i;
        end
        check("bounce_rise_lat", rise_at, 32'd11);

        // Async reset while HIGH.
        do_reset("rst_high");
        repeat (8) step(1'b0);

        // Short glitch: 4-cycle pulse must be ignored.
        clear_flags();
        repeat (4) step(1'b1);
        repeat (10) step(1'b0);
        check("glitch4_db", {31'd0, seen_db}, 32'd0);
        check("glitch4_busy", {31'd0, seen_busy}, 32'd1);

        // 5-cycle pulse is the shortest accepted press.
        clear_flags();
        repeat (5) step(1'b1);
        repeat (12) step(1'b0);
        check("pulse5_db", {31'd0, seen_db}, 32'd1);
        check("pulse5_pulses", pulse_cnt, 32'd1);

        // Reset during qualification, button held through reset.
        repeat (5) step(1'b1);
        check("midq_busy", {31'd0, pb_busy}, 32'd1);
        do_reset("rst_midq");
        clear_flags();
        rise_at = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1);
            if (pb_db && rise_at < 0) rise_at = i;
        end
        check("post_rst_rise_lat", rise_at, 32'd6);
        check("post_rst_pulses", pulse_cnt, 32'd1);
        repeat (10) step(1'b0);

        // Random bursts of alternating level.
        lvl = 1'b1;
        for (int b = 0; b < 24; b++) begin
            int len;
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) step(lvl);
            lvl = ~lvl;
        end
        repeat (10) step(1'b0);

        // End to end: bouncy press then bouncy release -> one clk_en pulse.
        clear_flags();
        for (int i = 0; i < 18; i++) step(i < 6 ? bounce_pat[5 - i] : 1'b1);
        for (int i = 0; i < 18; i++) step(i < 6 ? release_pat[5 - i] : 1'b0);
        check("e2e_pulses", pulse_cnt, 32'd1);
        check("e2e_pulse_width", pulse_max, 32'd1);
        check("e2e_final_db", {31'd0, pb_db}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
